// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Stall and flush sequencer for the 5-stage pipeline with a one-way dcache.
//   It combines three sources of disruption, listed here from highest to
//   lowest priority:
//     - dcache miss stall
//     - load-use hazard between the ID and EX stages
//     - taken branch or jump resolved in ID
//   From these it drives the per-stage write enables, the ID/EX bubble select
//   and the IF/ID flush. It also holds:
//     - a run/idle state machine
//     - a watchdog for long miss stalls
//     - three performance counters
//
// Ports
//   clk_i, rst_i        clock and synchronous active-high reset
//   start_i             leave IDLE and start running
//   IDinst_i            instruction held in IF/ID
//   EXregRTaddr_i       rt address of the instruction in ID/EX
//   EXmemRead_i         the instruction in ID/EX is a load
//   branch_taken_i      branch or jump resolved taken in ID
//   dcache_stall_i      dcache miss in progress
//   pc_write_o          PC load enable
//   ifid_write_o        IF/ID write enable
//   ifid_flush_o        clear IF/ID on this edge
//   idex_bubble_o       select zero control into ID/EX
//   pipe_write_o        write enable for ID/EX, EX/MEM and MEM/WB
//   state_o             00 IDLE, 01 RUN, 10 MEM_STALL
//   timeout_o           sticky watchdog flag
//   stall_cnt_o         number of dcache stall cycles
//   loaduse_cnt_o       number of load-use bubbles inserted
//   flush_cnt_o         number of IF/ID flushes
//
// state     | meaning
// ----------+----------------------------------------------------
// IDLE      | pipeline frozen, waiting for start_i
// RUN       | normal operation
// MEM_STALL | frozen on a dcache miss; leaves when the miss ends

module pipe_stall_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      IDinst_i,
    input  logic [4:0]       EXregRTaddr_i,
    input  logic             EXmemRead_i,
    input  logic             branch_taken_i,
    input  logic             dcache_stall_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_write_o,
    output logic [1:0]       state_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] loaduse_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RUN       = 2'b01,
        MEM_STALL = 2'b10
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic            active;
    logic            load_use;
    logic            stall_hit;
    logic            lu_hit;
    logic            br_hit;
    logic            unused_inst_bits;

    // Only the rs and rt fields of the ID instruction matter here.
    assign unused_inst_bits = ^{IDinst_i[31:26], IDinst_i[15:0]};

    assign active   = (state == RUN) || (state == MEM_STALL);
    assign load_use = EXmemRead_i && (EXregRTaddr_i != 5'd0) &&
                      ((IDinst_i[25:21] == EXregRTaddr_i) ||
                       (IDinst_i[20:16] == EXregRTaddr_i));

    // Priority decode. A branch that arrives together with a load-use is
    // dropped on purpose: ID is held, so the branch resolves again next cycle.
    assign stall_hit = active && dcache_stall_i;
    assign lu_hit    = active && !dcache_stall_i && load_use;
    assign br_hit    = active && !dcache_stall_i && !load_use && branch_taken_i;

    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_write_o  = 1'b0;
        if (active && !stall_hit) begin
            if (lu_hit) begin
                idex_bubble_o = 1'b1;
                pipe_write_o  = 1'b1;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                pipe_write_o = 1'b1;
                ifid_flush_o = br_hit;
            end
        end
    end

    assign state_o = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            wd_cnt        <= '0;
            timeout_o     <= 1'b0;
            stall_cnt_o   <= '0;
            loaduse_cnt_o <= '0;
            flush_cnt_o   <= '0;
        end else begin
            case (state)
                IDLE:          state <= start_i ? RUN : IDLE;
                RUN, MEM_STALL: state <= dcache_stall_i ? MEM_STALL : RUN;
                default:       state <= IDLE;
            endcase

            // The watchdog only reports. The stall itself is left in place.
            if (stall_hit) begin
                if (wd_cnt != WD_W'(TIMEOUT))
                    wd_cnt <= wd_cnt + WD_W'(1);
                if (wd_cnt >= WD_W'(TIMEOUT - 1))
                    timeout_o <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end

            if (stall_hit) stall_cnt_o   <= stall_cnt_o   + CNT_W'(1);
            if (lu_hit)    loaduse_cnt_o <= loaduse_cnt_o + CNT_W'(1);
            if (br_hit)    flush_cnt_o   <= flush_cnt_o   + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      inst;
    logic [4:0]       exrt;
    logic             memrd;
    logic             br;
    logic             dstall;
    logic             pc_w, ifid_w, ifid_fl, bub, pipe_w;
    logic [1:0]       st;
    logic             tmo;
    logic [CNT_W-1:0] c_stall, c_lu, c_fl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .IDinst_i       (inst),
        .EXregRTaddr_i  (exrt),
        .EXmemRead_i    (memrd),
        .branch_taken_i (br),
        .dcache_stall_i (dstall),
        .pc_write_o     (pc_w),
        .ifid_write_o   (ifid_w),
        .ifid_flush_o   (ifid_fl),
        .idex_bubble_o  (bub),
        .pipe_write_o   (pipe_w),
        .state_o        (st),
        .timeout_o      (tmo),
        .stall_cnt_o    (c_stall),
        .loaduse_cnt_o  (c_lu),
        .flush_cnt_o    (c_fl)
    );

    typedef struct {
        logic        start;
        logic [31:0] inst;
        logic [4:0]  exrt;
        logic        memrd;
        logic        br;
        logic        dstall;
        logic [4:0]  exp_en;   // {pc, ifid, flush, bubble, pipe}
        logic [1:0]  exp_st;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Advance one clock. Inputs are then changed at the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start = 0; inst = 32'h0; exrt = 5'd0; memrd = 0; br = 0; dstall = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    task automatic reset_and_start();
        do_reset();
        start = 1;
        cyc();
        start = 0;
    endtask

    function automatic logic [4:0] en_vec();
        return {pc_w, ifid_w, ifid_fl, bub, pipe_w};
    endfunction

    initial begin
        // start, inst, exrt, memrd, br, dstall, {pc,ifid,flush,bub,pipe}, state
        vecs[0]  = '{0, 32'h01095020, 5'd8, 1, 1, 1, 5'b00000, 2'b00};
        vecs[1]  = '{1, 32'h00000000, 5'd0, 0, 0, 0, 5'b00000, 2'b00};
        vecs[2]  = '{0, 32'h00000000, 5'd0, 0, 0, 0, 5'b11001, 2'b01};
        vecs[3]  = '{0, 32'h01095020, 5'd8, 1, 0, 0, 5'b00011, 2'b01};
        vecs[4]  = '{0, 32'h01095020, 5'd9, 1, 1, 0, 5'b00011, 2'b01};
        vecs[5]  = '{0, 32'h00095020, 5'd0, 1, 0, 0, 5'b11001, 2'b01};
        vecs[6]  = '{0, 32'h01095020, 5'd8, 0, 0, 0, 5'b11001, 2'b01};
        vecs[7]  = '{0, 32'h00000000, 5'd0, 0, 1, 0, 5'b11101, 2'b01};
        vecs[8]  = '{0, 32'h01095020, 5'd8, 1, 1, 1, 5'b00000, 2'b01};
        vecs[9]  = '{0, 32'h00000000, 5'd0, 0, 0, 1, 5'b00000, 2'b10};
        vecs[10] = '{0, 32'h00000000, 5'd0, 0, 1, 0, 5'b11101, 2'b10};
        vecs[11] = '{0, 32'h00000000, 5'd0, 0, 0, 0, 5'b11001, 2'b01};

        rst = 1;
        idle_inputs();
        @(negedge clk);
        do_reset();

        // After reset: idle, no enables, counters clear.
        chk("reset_state", st, 2'b00);
        chk("reset_en", en_vec(), 5'b00000);
        chk("reset_tmo", tmo, 0);
        chk("reset_cnt", {c_stall, c_lu, c_fl}, 0);

        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle_hold_state", st, 2'b00);
            chk("idle_hold_en", en_vec(), 5'b00000);
            cyc();
        end

        // Table vectors, applied back to back.
        for (int i = 0; i < 12; i++) begin
            start = vecs[i].start; inst = vecs[i].inst; exrt = vecs[i].exrt;
            memrd = vecs[i].memrd; br = vecs[i].br; dstall = vecs[i].dstall;
            #1;
            chk($sformatf("vec%0d_en", i), en_vec(), vecs[i].exp_en);
            chk($sformatf("vec%0d_state", i), st, vecs[i].exp_st);
            cyc();
        end
        idle_inputs();
        #1;
        chk("vec_stall_cnt", c_stall, 2);
        chk("vec_lu_cnt", c_lu, 2);
        chk("vec_flush_cnt", c_fl, 2);

        // A 4-cycle miss masks a load-use and a branch. The bubble follows at once.
        reset_and_start();
        inst = 32'h01095020; exrt = 5'd8; memrd = 1; br = 1; dstall = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("miss_en", en_vec(), 5'b00000);
            cyc();
        end
        dstall = 0;
        #1;
        chk("miss_exit_en", en_vec(), 5'b00011);
        chk("miss_exit_state", st, 2'b10);
        cyc();
        idle_inputs();
        #1;
        chk("miss_stall_cnt", c_stall, 4);
        chk("miss_flush_cnt", c_fl, 0);
        chk("miss_lu_cnt", c_lu, 1);
        chk("miss_state", st, 2'b01);

        // The watchdog counts only consecutive stall cycles.
        reset_and_start();
        dstall = 1;
        for (int i = 0; i < 5; i++) cyc();
        dstall = 0;
        cyc();
        dstall = 1;
        for (int i = 0; i < 7; i++) cyc();
        #1;
        chk("wd_not_consec", tmo, 0);

        // With a 12-cycle stall, timeout_o rises after the 8th stall cycle.
        reset_and_start();
        dstall = 1;
        for (int k = 1; k <= 12; k++) begin
            #1;
            chk($sformatf("wd_cyc%0d", k), tmo, (k >= 9) ? 1 : 0);
            chk("wd_en", en_vec(), 5'b00000);
            cyc();
        end
        dstall = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wd_sticky", tmo, 1);
            chk("wd_run_en", en_vec(), 5'b11001);
            cyc();
        end
        #1;
        chk("wd_stall_cnt", c_stall, 12);

        // A reset during a miss clears everything.
        dstall = 1; br = 1;
        cyc();
        #1;
        chk("pre_rst_state", st, 2'b10);
        rst = 1;
        cyc();
        rst = 0;
        #1;
        chk("rst_state", st, 2'b00);
        chk("rst_tmo", tmo, 0);
        chk("rst_cnt", {c_stall, c_lu, c_fl}, 0);
        chk("rst_en", en_vec(), 5'b00000);
        cyc();
        #1;
        chk("rst_idle_stall_cnt", c_stall, 0);

        // The flush counter wraps modulo 2^CNT_W.
        reset_and_start();
        br = 1;
        for (int i = 0; i < 255; i++) cyc();
        #1;
        chk("flush_255", c_fl, 255);
        chk("flush_en", en_vec(), 5'b11101);
        cyc();
        #1;
        chk("flush_wrap", c_fl, 0);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_time got=timeout want=finish");
        $fatal(1);
    end

endmodule
